clock_manager: RTL and testbench
================================

# clock_manager

Parametrised clock-domain manager for the PLL-derived system clock. It qualifies the raw PLL lock indication and holds the design in reset until lock has been stable for a programmable interval. It detects and records lock loss. Once running, it generates NUM_CH independent fractional-rate clock-enable strobes from NCO phase accumulators. It sits directly after the PLL instance and feeds reset and tick enables to every downstream block.

## Interface
- NUM_CH, 2: number of NCO tick channels (1..8)
- ACC_W, 24: phase accumulator width per channel (4..32)
- LOCK_CYCLES, 1024: consecutive synchronised-lock cycles required before release (≥ 2)
- clock_in  in  1  system clock (PLL output); the only clock
- reset  in  1  synchronous, active-high reset
- pll_locked  in  1  raw PLL lock, asynchronous to clock_in; resynchronised internally
- inc  in  NUM_CH*ACC_W  per-channel phase increment; channel i occupies bits [i*ACC_W +: ACC_W]
- clr_lost  in  1  single-cycle clear for lock_lost
- sys_reset  out  1  active-high reset to downstream logic
- ready  out  1  high only while in RUN
- tick  out  NUM_CH  per-channel one-cycle enable strobes
- lock_lost  out  1  sticky lock-loss flag

## Operation
- Lock synchroniser: two-flop chain on pll_locked. The second flop is lock_s, the only lock signal used internally.
- FSM states:
  - WAIT_LOCK: lock_s=1 → QUALIFY, qual_cnt ← 0.
  - QUALIFY: lock_s=0 → WAIT_LOCK, qual_cnt ← 0. Else if qual_cnt == LOCK_CYCLES-1 → RUN. Else qual_cnt++.
  - RUN: lock_s=0 → LOST.
  - LOST: unconditional → WAIT_LOCK next cycle.
- qual_cnt width: clog2(LOCK_CYCLES). It never wraps.
- ready = (state == RUN); sys_reset = !ready. Both are decoded from the state register, so they are glitch-free.
- lock_lost is set on the RUN→LOST transition and cleared by reset or clr_lost. If set and clear occur in the same cycle, set wins.
- NCO, per channel i:
  - In RUN: {carry, acc[i]} ← acc[i] + inc_i, and tick[i] ← carry. The register updates modulo 2^ACC_W.
  - Outside RUN: acc[i] ← 0 and tick[i] ← 0.
- Average tick rate = f_clock_in · inc_i / 2^ACC_W. inc_i = 0 yields no ticks. inc_i = 2^ACC_W−1 yields ticks on all but one cycle per 2^ACC_W.
- inc is sampled every cycle. A change affects the very next accumulation, and the accumulator is not reset.
- Channels are fully independent and share no state.

## Timing
- Reset (synchronous, overrides everything):
  - state=WAIT_LOCK, synchroniser flops=0, qual_cnt=0, all acc=0.
  - Outputs: sys_reset=1, ready=0, tick=0, lock_lost=0.
- Reset asserted mid-RUN takes effect at the next edge. lock_lost is not set by reset.
- Release latency: if pll_locked is first sampled high at edge 1 and stays high, lock_s is high after edge 2 and QUALIFY is entered at edge 3. RUN, ready=1 and sys_reset=0 all take effect after edge LOCK_CYCLES+3.
- A lock_s drop during QUALIFY restarts the full count. There is no partial credit.
- Loss latency: if pll_locked is first sampled low at edge k during RUN, then:
  - lock_s goes low after edge k+1;
  - LOST is entered after edge k+2, with sys_reset=1, ready=0, lock_lost=1, acc=0, tick=0;
  - WAIT_LOCK is entered after edge k+3.
- Tick latency: the first tick of channel i occurs ceil(2^ACC_W / inc_i) cycles after RUN entry and lasts exactly one cycle.
- tick is never high while sys_reset is high.

## Test plan
- Clean lock-up: LOCK_CYCLES=4, pll_locked high from edge 1 → ready=1 and sys_reset=0 after edge 7. Before that edge, sys_reset=1 and tick=0.
- Lock glitch during qualification: LOCK_CYCLES=8, with pll_locked low for one cycle 3 cycles into QUALIFY → the count restarts; ready is delayed by the full 8 cycles after lock_s returns high; lock_lost stays 0.
- NCO rate: ACC_W=8, inc0=64, inc1=96 →
  - channel 0 ticks on RUN cycles 4, 8, 12, …;
  - channel 1 ticks on cycles 3, 6, 8, 11, 14, 16, … (3 ticks per 8 cycles);
  - inc1=0 → no ticks.
- Lock loss in RUN: drop pll_locked at edge k → LOST after edge k+2 (sys_reset=1, lock_lost=1, tick=0, acc=0), then WAIT_LOCK. Re-lock repeats the full qualification. clr_lost clears lock_lost; clr_lost coincident with a new loss leaves it at 1.
- Reset mid-operation: assert reset during RUN with ticks active → after the next edge all outputs return to reset values, including lock_lost=0. Deassert with pll_locked high → ready returns after LOCK_CYCLES+3 edges.
- Increment change: ACC_W=8, inc0 switched from 64 to 128 at acc=192 → the next edge gives acc=64 with tick=1, and ticks then occur every 2 cycles.

Source files
------------

// File: rtl/clock_manager.sv
// PLL lock qualifier and reset sequencer with NUM_CH fractional-rate NCO tick generators.
// Downstream logic is held in reset until the resynchronised lock has been stable for LOCK_CYCLES.
module clock_manager #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    pll_locked,
  input  logic [NUM_CH*ACC_W-1:0] inc,
  input  logic                    clr_lost,
  output logic                    sys_reset,
  output logic                    ready,
  output logic [NUM_CH-1:0]       tick,
  output logic                    lock_lost
);

  localparam int CNT_W = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  // RUN owns a dedicated state bit so ready/sys_reset come straight off one flop.
  localparam int RUN_BIT = 2;

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'b000,
    S_QUALIFY   = 3'b001,
    S_LOST      = 3'b010,
    S_RUN       = 3'b100
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   qual_cnt_q, qual_cnt_d;
  logic               meta_q, lock_s_q;
  logic               lock_lost_q, lock_lost_d;
  logic               nco_run;
  logic [ACC_W-1:0]   acc_q [NUM_CH];
  logic [ACC_W-1:0]   acc_d [NUM_CH];
  logic [ACC_W:0]     sum   [NUM_CH];
  logic [NUM_CH-1:0]  tick_q, tick_d;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      meta_q   <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      meta_q   <= pll_locked;
      lock_s_q <= meta_q;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q    <= S_WAIT_LOCK;
      qual_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      qual_cnt_q <= qual_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    qual_cnt_d = qual_cnt_q;
    case (state_q)
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d    = S_QUALIFY;
          qual_cnt_d = '0;
        end
      end
      S_QUALIFY: begin
        if (!lock_s_q) begin
          state_d    = S_WAIT_LOCK;
          qual_cnt_d = '0;
        end else if (qual_cnt_q == CNT_LAST) begin
          state_d = S_RUN;
        end else begin
          qual_cnt_d = qual_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s_q) state_d = S_LOST;
      end
      S_LOST:  state_d = S_WAIT_LOCK;
      default: state_d = S_WAIT_LOCK;
    endcase
  end

  always_comb begin
    ready     = state_q[RUN_BIT];
    sys_reset = !state_q[RUN_BIT];
  end

  // A new loss dominates a coincident clear request.
  always_comb begin
    if ((state_q == S_RUN) && (state_d == S_LOST)) lock_lost_d = 1'b1;
    else if (clr_lost)                             lock_lost_d = 1'b0;
    else                                           lock_lost_d = lock_lost_q;
  end

  always_ff @(posedge clock_in) begin
    if (reset) lock_lost_q <= 1'b0;
    else       lock_lost_q <= lock_lost_d;
  end

  // Accumulate only while staying in RUN, so the loss edge already clears acc and tick.
  assign nco_run = (state_q == S_RUN) && (state_d == S_RUN);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, inc[i*ACC_W +: ACC_W]};
      if (nco_run) begin
        acc_d[i]  = sum[i][ACC_W-1:0];
        tick_d[i] = sum[i][ACC_W];
      end else begin
        acc_d[i]  = '0;
        tick_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
      tick_q <= tick_d;
    end
  end

  assign tick      = tick_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_clock_manager.sv
// Scoreboard bench for clock_manager: stimulus queues hand-derived per-edge outputs,
// a negedge monitor pops and compares them against {sys_reset, ready, tick[1], tick[0], lock_lost}.
module tb_clock_manager;

  localparam int NUM_CH      = 2;
  localparam int ACC_W       = 8;
  localparam int LOCK_CYCLES = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    pll_locked;
  logic [NUM_CH*ACC_W-1:0] inc;
  logic                    clr_lost;
  logic                    sys_reset;
  logic                    ready;
  logic [NUM_CH-1:0]       tick;
  logic                    lock_lost;

  typedef struct {
    int         tag;
    logic [4:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   ecnt    = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  clock_manager #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clock_in  (clk),
    .reset     (reset),
    .pll_locked(pll_locked),
    .inc       (inc),
    .clr_lost  (clr_lost),
    .sys_reset (sys_reset),
    .ready     (ready),
    .tick      (tick),
    .lock_lost (lock_lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Queue the outputs expected right after the coming edge, then advance past it.
  task automatic step(input string nm, input logic sr, input logic rdy,
                      input logic t1, input logic t0, input logic ll);
    exp_t e;
    e.tag  = ecnt + 1;
    e.exp  = {sr, rdy, t1, t0, ll};
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag <= ecnt) begin
        e   = sb.pop_front();
        act = {sys_reset, ready, tick[1], tick[0], lock_lost};
        n_tests++;
        if (e.tag != ecnt || act !== e.exp) begin
          n_fail++;
          $display("FAIL %s edge=%0d (queued for %0d) got {sr,rdy,t1,t0,ll}=%b want %b",
                   e.name, ecnt, e.tag, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d expectations pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset      = 1'b1;
    pll_locked = 1'b0;
    clr_lost   = 1'b0;
    inc        = {8'd96, 8'd64};

    repeat (3) step("reset_state", 1, 0, 0, 0, 0);

    // Clean lock-up: lock sampled at edge 1, RUN after edge LOCK_CYCLES+3 = 7.
    reset      = 1'b0;
    pll_locked = 1'b1;
    repeat (6) step("lockup_hold", 1, 0, 0, 0, 0);
    step("lockup_ready", 0, 1, 0, 0, 0);

    // inc0=64 ticks every 4th RUN cycle; inc1=96 ticks 3 times per 8 cycles.
    for (int n = 1; n <= 16; n++)
      step("nco_rate", 0, 1,
           (n == 3 || n == 6 || n == 8 || n == 11 || n == 14 || n == 16),
           (n % 4 == 0), 0);

    inc[15:8] = 8'd0;
    for (int n = 17; n <= 19; n++) step("nco_inc_zero", 0, 1, 0, 0, 0);

    // acc0 is 192 here; 192+128 wraps to 64 with a carry, then ticks every 2 cycles.
    inc[7:0] = 8'd128;
    for (int n = 20; n <= 26; n++) step("inc_change", 0, 1, 0, (n % 2 == 0), 0);

    // Lock loss at edge k: still RUN at k and k+1, LOST at k+2 with clr_lost coincident.
    pll_locked = 1'b0;
    step("loss_k", 0, 1, 0, 0, 0);
    step("loss_k1", 0, 1, 0, 1, 0);
    clr_lost = 1'b1;
    step("loss_set_wins", 1, 0, 0, 0, 1);
    clr_lost = 1'b0;
    step("loss_wait_lock", 1, 0, 0, 0, 1);
    clr_lost = 1'b1;
    step("clr_lost", 1, 0, 0, 0, 0);
    clr_lost = 1'b0;
    step("lost_cleared", 1, 0, 0, 0, 0);

    // Re-lock with a one-cycle glitch two cycles into QUALIFY: RUN lands at m+10.
    inc[15:8]  = 8'd96;
    pll_locked = 1'b1;
    repeat (3) step("glitch_hold", 1, 0, 0, 0, 0);
    pll_locked = 1'b0;
    step("glitch_hold", 1, 0, 0, 0, 0);
    pll_locked = 1'b1;
    repeat (6) step("glitch_hold", 1, 0, 0, 0, 0);
    step("glitch_ready", 0, 1, 0, 0, 0);

    // Accumulators restart from zero: inc0=128 ticks on even cycles, inc1=96 on 3 and 6.
    for (int n = 1; n <= 6; n++)
      step("relock_nco", 0, 1, (n == 3 || n == 6), (n % 2 == 0), 0);

    pll_locked = 1'b0;
    step("loss2_k", 0, 1, 0, 0, 0);
    step("loss2_k1", 0, 1, 1, 1, 0);
    step("loss2_lost", 1, 0, 0, 0, 1);
    step("loss2_wait_lock", 1, 0, 0, 0, 1);

    pll_locked = 1'b1;
    repeat (6) step("relock2_hold", 1, 0, 0, 0, 1);
    step("relock2_ready", 0, 1, 0, 0, 1);
    for (int n = 1; n <= 4; n++)
      step("relock2_nco", 0, 1, (n == 3), (n % 2 == 0), 1);

    // Reset mid-RUN with ticks active and lock_lost set.
    reset = 1'b1;
    step("mid_reset", 1, 0, 0, 0, 0);
    step("mid_reset_hold", 1, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (6) step("rerun_hold", 1, 0, 0, 0, 0);
    step("rerun_ready", 0, 1, 0, 0, 0);
    step("rerun_nco", 0, 1, 0, 0, 0);
    step("rerun_nco", 0, 1, 0, 1, 0);
    step("rerun_nco", 0, 1, 1, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
